// File: rtl/wb_port_arbiter_if.sv
// Bundle of the write-back, MUL/DIV and register-file write port signals
// that pass through the arbiter.
interface wb_port_arbiter_if;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  logic        stall_pipe;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  modport master (
    output wb_valid, wb_rd, wb_data, md_valid, md_rd, md_data,
    input  md_ready, stall_pipe, rf_we, rf_rd, rf_wdata
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, md_valid, md_rd, md_data,
    output md_ready, stall_pipe, rf_we, rf_rd, rf_wdata
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: pipeline write-back has priority, MUL/DIV
// results queue in an in-order buffer and get a forced stall slot when starved.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst,
  wb_port_arbiter_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {GRANT_NONE, GRANT_WB, GRANT_MD} grant_e;

  logic [DEPTH-1:0] buf_valid;
  logic [4:0]       buf_rd   [DEPTH];
  logic [31:0]      buf_data [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic [SW-1:0]    starve_cnt;

  grant_e grant;
  logic   head_valid;
  logic   enq;
  logic   pop;
  logic   starved;
  logic   starve_fire;

  assign bus.md_ready = (count < CW'(DEPTH));

  always_comb begin
    head_valid  = (count != '0) && buf_valid[head];
    grant       = GRANT_NONE;
    if (bus.stall_pipe) begin
      if (head_valid) grant = GRANT_MD;
    end else if (bus.wb_valid && (bus.wb_rd != 5'd0)) begin
      grant = GRANT_WB;
    end else if (head_valid) begin
      grant = GRANT_MD;
    end
    enq         = bus.md_valid && bus.md_ready && (bus.md_rd != 5'd0);
    // A killed head leaves the buffer without consuming the port.
    pop         = (count != '0) && ((grant == GRANT_MD) || !buf_valid[head]);
    starved     = head_valid && (grant != GRANT_MD) && !bus.stall_pipe;
    starve_fire = starved && (starve_cnt == SW'(STARVE_LIMIT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid      <= '0;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      starve_cnt     <= '0;
      bus.stall_pipe <= 1'b0;
      bus.rf_we      <= 1'b0;
      bus.rf_rd      <= 5'd0;
      bus.rf_wdata   <= 32'd0;
    end else begin
      // WAW kill only touches entries already stored; the tail slot written
      // below is free this cycle, so a same-cycle enqueue survives.
      for (int i = 0; i < DEPTH; i++) begin
        if ((grant == GRANT_WB) && buf_valid[i] && (buf_rd[i] == bus.wb_rd))
          buf_valid[i] <= 1'b0;
      end
      if (pop) begin
        buf_valid[head] <= 1'b0;
        head            <= head + PW'(1);
      end
      if (enq) begin
        buf_valid[tail] <= 1'b1;
        buf_rd[tail]    <= bus.md_rd;
        buf_data[tail]  <= bus.md_data;
        tail            <= tail + PW'(1);
      end
      if (enq && !pop)
        count <= count + CW'(1);
      else if (!enq && pop)
        count <= count - CW'(1);

      if (starve_fire)
        starve_cnt <= '0;
      else if (starved)
        starve_cnt <= starve_cnt + SW'(1);
      else if ((grant == GRANT_MD) || (buf_valid == '0))
        starve_cnt <= '0;
      bus.stall_pipe <= starve_fire;

      case (grant)
        GRANT_WB: begin
          bus.rf_we    <= 1'b1;
          bus.rf_rd    <= bus.wb_rd;
          bus.rf_wdata <= bus.wb_data;
        end
        GRANT_MD: begin
          bus.rf_we    <= 1'b1;
          bus.rf_rd    <= buf_rd[head];
          bus.rf_wdata <= buf_data[head];
        end
        default: begin
          bus.rf_we    <= 1'b0;
          bus.rf_rd    <= 5'd0;
          bus.rf_wdata <= 32'd0;
        end
      endcase
    end
  end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbiter for the single register-file write port. It shares the port between the pipeline write-back stage and the multi-cycle MUL/DIV unit. Pipeline writes have priority. MUL/DIV results wait in a small in-order buffer and drain into idle slots. If the buffer is starved, the arbiter forces a one-cycle pipeline stall so the buffer can drain. The block sits between the write-back stage and the decoder's register file, replacing the direct write-back → register-file connection.

## Interface
- DEPTH, 2: MUL/DIV result buffer entries; power of two, ≥2.
- STARVE_LIMIT, 4: consecutive starved cycles before a forced stall; ≥1.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- wb_valid  input  1  pipeline write-back request this cycle.
- wb_rd  input  5  pipeline destination register.
- wb_data  input  32  pipeline write data.
- md_valid  input  1  MUL/DIV result offered.
- md_rd  input  5  MUL/DIV destination register.
- md_data  input  32  MUL/DIV result.
- md_ready  output  1  buffer can accept a result; md_ready = (count < DEPTH).
- stall_pipe  output  1  registered; while 1, the write-back stage holds its entry and re-presents it next cycle.
- rf_we  output  1  registered register-file write enable.
- rf_rd  output  5  registered write address.
- rf_wdata  output  32  registered write data.

## Operation
- Buffer: in-order FIFO of DEPTH entries {valid, rd, data}, with head/tail pointers and count.
- Enqueue: happens when md_valid && md_ready.
  - If md_rd == 0, the handshake completes but nothing is stored.
- Grant, evaluated each cycle in priority order:
  1. If stall_pipe == 1: grant the buffer head if it is valid. wb_valid is ignored.
  2. Else if wb_valid && wb_rd != 0: grant the pipeline.
  3. Else if the head is valid: grant the buffer.
  4. Else: no grant.
- A pipeline request with wb_rd == 0 never writes and never blocks the buffer.
- Buffer grant pops the head.
- WAW kill:
  - On a pipeline grant, every entry stored at the start of the cycle whose rd == wb_rd has its valid bit cleared.
  - A result being enqueued in the same cycle is never killed.
- Killed head: popped in any cycle without using the port; no write is produced for it.
- Starve counter:
  - Increments in each cycle where the head is valid, the head is not granted, and stall_pipe == 0.
  - Clears whenever the head is granted or the buffer holds no valid entry.
  - When it would reach STARVE_LIMIT: stall_pipe <= 1 for exactly one cycle, and the counter clears.
- Forced stall with no valid head (the head was killed): the stall cycle still occurs, with no write.
- Enqueue and pop in the same cycle are allowed; count is unchanged.

## Timing
- Reset (rst == 1 at an edge): rf_we = 0, rf_rd = 0, rf_wdata = 0, stall_pipe = 0. Buffer is emptied, pointers = 0, count = 0, starve counter = 0.
- md_ready is 1 in the first cycle after reset.
- Reset mid-operation discards all buffered results without writing them.
- Latency: a grant in cycle N appears on rf_we/rf_rd/rf_wdata in cycle N+1. Those outputs hold for exactly one cycle.
- Minimum MUL/DIV path: accept in cycle N → earliest grant in N+1 → write visible in N+2.
- md_ready depends only on registered count; there is no same-cycle pass-through when full.
- Starvation: the head is valid and ungranted for STARVE_LIMIT consecutive cycles N..N+L−1 → stall_pipe = 1 in N+L → head written in N+L+1.
- At most one register-file write per cycle. Pipeline results are never dropped: they are written either in the cycle presented or in the cycle after a stall.
- rf_rd == 0 with rf_we == 1 never occurs.

## Test plan
- Reset: assert rst mid-burst with 2 buffered entries → next cycle all outputs 0, md_ready = 1; the buffered results are never written.
- Idle drain: md result {rd = 5, data = 0x1234_5678} with wb_valid = 0 → accepted; rf_we = 1, rf_rd = 5, rf_wdata = 0x1234_5678 two cycles later.
- Priority and fill: wb_valid = 1 every cycle (rd = 1..), 3 md results offered back-to-back → md_ready drops after 2 accepts; only pipeline writes appear on the port.
- Starvation: with pipeline saturated and buffer nonempty, STARVE_LIMIT = 4 → stall_pipe high for one cycle after 4 starved cycles. The buffer head is written next; the held pipeline write follows with unchanged rd/data.
- WAW kill: buffer holds {rd = 7, 0xAAAA}; pipeline writes rd = 7, 0xBBBB → 0xAAAA is never written; register 7 ends as 0xBBBB.
- x0 filtering: md_rd = 0 and wb_rd = 0 requests → handshakes complete, rf_we stays 0, count unchanged.
